// File: rtl/mtr_gate_drv.sv
// Motor gate driver: 11-bit PWM, per-phase select decode and dead-time
// insertion producing six FET gate enables (green, yellow, blue phases).
module mtr_gate_drv #(
    parameter int DEAD_CYC = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] duty,
    input  logic [1:0]  selGrn,
    input  logic [1:0]  selYlw,
    input  logic [1:0]  selBlu,
    output logic        highGrn,
    output logic        lowGrn,
    output logic        highYlw,
    output logic        lowYlw,
    output logic        highBlu,
    output logic        lowBlu,
    output logic        pwm_synch
);

    localparam logic [1:0]  SEL_HI_Z   = 2'b00;
    localparam logic [1:0]  SEL_R_CURR = 2'b01;
    localparam logic [1:0]  SEL_F_CURR = 2'b10;
    localparam logic [1:0]  SEL_R_BRK  = 2'b11;
    localparam logic [7:0]  DEAD_LIM   = 8'(DEAD_CYC);
    localparam logic [10:0] CNT_LAST   = 11'h7FF;

    logic [10:0] cnt;
    logic [10:0] duty_q;
    logic        pwm;
    logic [2:0][1:0] sel;

    assign sel = {selBlu, selYlw, selGrn};

    // duty only reloads at the period boundary so a period is never torn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            duty_q    <= '0;
            pwm       <= 1'b0;
            pwm_synch <= 1'b0;
        end else begin
            cnt       <= cnt + 11'd1;
            pwm       <= (cnt < duty_q);
            pwm_synch <= (cnt == '0);
            if (cnt == CNT_LAST) begin
                duty_q <= duty;
            end
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_phase
        logic [1:0] pair_d;
        logic [1:0] des_q;
        logic [7:0] dcnt;
        logic [1:0] gate_q;

        always_comb begin
            pair_d = 2'b00;
            case (sel[p])
                SEL_HI_Z:   pair_d = 2'b00;
                SEL_R_CURR: pair_d = {~pwm, pwm};
                SEL_F_CURR: pair_d = {pwm, ~pwm};
                SEL_R_BRK:  pair_d = {1'b0, pwm};
                default:    pair_d = 2'b00;
            endcase
        end

        // any change of the wanted pair, PWM edge or select step alike, restarts dead time
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                des_q  <= 2'b00;
                dcnt   <= '0;
                gate_q <= 2'b00;
            end else if (pair_d != des_q) begin
                des_q  <= pair_d;
                dcnt   <= '0;
                gate_q <= 2'b00;
            end else if (dcnt != DEAD_LIM) begin
                dcnt   <= dcnt + 8'd1;
                gate_q <= 2'b00;
            end else begin
                gate_q <= (des_q == 2'b11) ? 2'b00 : des_q;
            end
        end
    end

    assign highGrn = g_phase[0].gate_q[1];
    assign lowGrn  = g_phase[0].gate_q[0];
    assign highYlw = g_phase[1].gate_q[1];
    assign lowYlw  = g_phase[1].gate_q[0];
    assign highBlu = g_phase[2].gate_q[1];
    assign lowBlu  = g_phase[2].gate_q[0];

endmodule

// File: tb/tb_mtr_gate_drv.sv
// Bench for mtr_gate_drv: directed scenarios plus random stimulus, checked
// every cycle against a time-indexed model of the PWM and dead-time rules.
module tb_mtr_gate_drv;

    localparam int DC  = 32;
    localparam int HL  = DC + 2;
    localparam int PER = 2048;

    logic        clk;
    logic        rst_n;
    logic [10:0] duty;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_synch;

    int errors = 0;
    int checks = 0;

    mtr_gate_drv #(.DEAD_CYC(DC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .duty     (duty),
        .selGrn   (selGrn),
        .selYlw   (selYlw),
        .selBlu   (selBlu),
        .highGrn  (highGrn),
        .lowGrn   (lowGrn),
        .highYlw  (highYlw),
        .lowYlw   (lowYlw),
        .highBlu  (highBlu),
        .lowBlu   (lowBlu),
        .pwm_synch(pwm_synch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: edges since reset release, captured duty, pwm level, and the
    // recent history of wanted pairs per phase (a gate is on only when its
    // wanted pair has been identical for the last DEAD_CYC+2 samples)
    int          m_k;
    logic [10:0] m_duty_q;
    logic        m_pwm;
    logic        m_synch;
    logic [1:0]  hist [3][HL];
    logic [5:0]  m_gates;

    int on_cnt [6];
    int both_cnt;
    int synch_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] want(input logic [1:0] s, input logic p);
        case (s)
            2'b01:   return {~p, p};
            2'b10:   return {p, ~p};
            2'b11:   return {1'b0, p};
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_k      = 0;
        m_duty_q = '0;
        m_pwm    = 1'b0;
        m_synch  = 1'b0;
        m_gates  = '0;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < HL; i++) hist[p][i] = 2'b11;
    endtask

    task automatic model_edge();
        logic [1:0] s [3];
        logic [1:0] g [3];
        int         c;
        bit         st;
        s[0] = selGrn; s[1] = selYlw; s[2] = selBlu;
        c = m_k % PER;
        for (int p = 0; p < 3; p++) begin
            for (int i = HL - 1; i > 0; i--) hist[p][i] = hist[p][i-1];
            hist[p][0] = want(s[p], m_pwm);
            st = 1'b1;
            for (int i = 1; i < HL; i++) if (hist[p][i] != hist[p][0]) st = 1'b0;
            g[p] = st ? hist[p][0] : 2'b00;
        end
        m_gates = {g[0], g[1], g[2]};
        m_synch = (c == 0);
        m_pwm   = (c < int'(m_duty_q));
        if (c == PER - 1) m_duty_q = duty;
        m_k++;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 6; i++) on_cnt[i] = 0;
        both_cnt  = 0;
        synch_cnt = 0;
    endtask

    task automatic cycle();
        logic [6:0] obs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        obs = {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_synch};
        chk("cycle_outputs", int'(obs), int'({m_gates, m_synch}));
        for (int i = 0; i < 6; i++) on_cnt[i] += int'(obs[6-i]);
        if ((highGrn && lowGrn) || (highYlw && lowYlw) || (highBlu && lowBlu)) both_cnt++;
        synch_cnt += int'(pwm_synch);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // stops on the last sample of a period so the next PER cycles form one period
    task automatic run_to_period_end();
        do cycle(); while ((m_k % PER) != 0);
    endtask

    task automatic set_sel(input logic [1:0] g, input logic [1:0] y, input logic [1:0] b);
        selGrn = g; selYlw = y; selBlu = b;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        duty  = 11'h400;
        set_sel(2'b10, 2'b10, 2'b10);
        #1 rst_n = 1'b0;
        model_reset();
        clr_counts();

        // reset held
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_synch}), 0);
        rst_n = 1'b1;

        // gates stay off through the first dead time; synch once per period
        n = 0;
        do begin cycle(); n++; end
        while (!(highGrn | lowGrn | highYlw | lowYlw | highBlu | lowBlu) && n < 200);
        chk("first_gate_on_edge", n, DC + 2);
        run_cycles(2 * PER - n);
        chk("synch_pulses_2_periods", synch_cnt, 2);

        // F_CURR on green only, duty 0x400
        set_sel(2'b10, 2'b00, 2'b00);
        run_to_period_end();
        run_to_period_end();
        clr_counts();
        run_cycles(PER);
        chk("fcurr_highGrn", on_cnt[0], 1024 - (DC + 1));
        chk("fcurr_lowGrn", on_cnt[1], 2048 - 1024 - (DC + 1));
        chk("fcurr_ylw_blu", on_cnt[2] + on_cnt[3] + on_cnt[4] + on_cnt[5], 0);
        chk("fcurr_both_on", both_cnt, 0);
        chk("fcurr_synch", synch_cnt, 1);

        // brake on all phases, duty 0x600
        duty = 11'h600;
        set_sel(2'b11, 2'b11, 2'b11);
        run_to_period_end();
        run_to_period_end();
        clr_counts();
        run_cycles(PER);
        chk("brake_highs", on_cnt[0] + on_cnt[2] + on_cnt[4], 0);
        chk("brake_lowGrn", on_cnt[1], 1536 - (DC + 1));
        chk("brake_lowYlw", on_cnt[3], 1536 - (DC + 1));
        chk("brake_lowBlu", on_cnt[5], 1536 - (DC + 1));

        // duty change mid-period takes effect one period later
        duty = 11'h100;
        set_sel(2'b10, 2'b00, 2'b00);
        run_to_period_end();
        run_to_period_end();
        clr_counts();
        run_cycles(500);
        duty = 11'h700;
        run_cycles(PER - 500);
        chk("midchg_cur_highGrn", on_cnt[0], 256 - (DC + 1));
        clr_counts();
        run_cycles(PER);
        chk("midchg_next_highGrn", on_cnt[0], 1792 - (DC + 1));
        chk("midchg_next_lowGrn", on_cnt[1], 2048 - 1792 - (DC + 1));

        // commutation step F_CURR -> R_CURR while pwm is high
        run_to_period_end();
        run_cycles(200);
        chk("commut_pre_highGrn", int'(highGrn), 1);
        selGrn = 2'b01;
        cycle();
        chk("commut_high_falls", int'({highGrn, lowGrn}), 0);
        n = 0;
        do begin cycle(); n++; end while (!lowGrn && n < 80);
        chk("commut_low_rise_delay", n, DC + 1);
        selGrn = 2'b10;
        cycle();
        chk("toggle_low_falls", int'(lowGrn), 0);
        run_cycles(4);
        selGrn = 2'b01;
        n = 0;
        do begin cycle(); n++; end while (!lowGrn && n < 80);
        chk("toggle_restart_delay", n, DC + 2);

        // duty 0: low gate continuously on
        duty = 11'h000;
        set_sel(2'b10, 2'b00, 2'b00);
        run_to_period_end();
        run_to_period_end();
        clr_counts();
        run_cycles(PER);
        chk("duty0_highGrn", on_cnt[0], 0);
        chk("duty0_lowGrn", on_cnt[1], PER);

        // asynchronous reset mid-period
        run_cycles(300);
        chk("prereset_lowGrn", int'(lowGrn), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_synch}), 0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        run_cycles(100);

        // duty 2047: the one-cycle low phase never reaches the low gate
        duty = 11'h7FF;
        run_to_period_end();
        run_to_period_end();
        clr_counts();
        run_cycles(PER);
        chk("duty2047_highGrn", on_cnt[0], 2047 - (DC + 1));
        chk("duty2047_lowGrn", on_cnt[1], 0);

        // random duty/select segments, including short ones that restart dead time
        for (int seg = 0; seg < 60; seg++) begin
            duty = 11'($urandom_range(0, 2047));
            set_sel(2'($urandom), 2'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) run_cycles($urandom_range(1, 40));
            else run_cycles($urandom_range(41, 250));
        end
        clr_counts();
        run_cycles(PER);
        chk("random_both_on", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mtr_gate_drv.md
# mtr_gate_drv

Converts the commutation block's per-phase select codes and 11-bit duty into six FET gate drives (high/low for the green, yellow and blue phases). It sits between the commutation logic and the pads. Internally it contains:
- a free-running 11-bit PWM generator with period-synchronous duty loading;
- per-phase decode of the select codes;
- per-phase dead-time insertion, so the high and low FETs of a phase are never on together.

## Interface
- DEAD_CYC, 32: dead-time length in clk cycles; legal 1..255. Counter width is 8 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- duty  input  11  requested PWM high time in clk cycles, out of 2048.
- selGrn  input  2  green phase select. Encoding: 00 HI_Z, 01 R_CURR, 10 F_CURR, 11 R_BRK.
- selYlw  input  2  yellow phase select; same encoding.
- selBlu  input  2  blue phase select; same encoding.
- highGrn, lowGrn  output  1 each  green high-side and low-side gate enables.
- highYlw, lowYlw  output  1 each  yellow gate enables.
- highBlu, lowBlu  output  1 each  blue gate enables.
- pwm_synch  output  1  one-cycle pulse marking the start of each PWM period, for ADC sampling alignment.

## Operation
- **PWM counter `cnt`** (11 bits): increments every clk and wraps 2047→0.
- **Duty capture `duty_q`**: loads `duty` only on the edge where `cnt`==2047. Mid-period changes to `duty` have no effect until the next period.
- **`pwm`** (registered): `pwm` <= (`cnt` < `duty_q`). It is high for exactly `duty_q` cycles per 2048-cycle period.
  - `duty_q`=0 gives `pwm` constantly 0.
  - `duty_q`=2047 gives `pwm` low for 1 cycle per period.
- **`pwm_synch`** (registered): <= (`cnt`==0).
- **Per-phase decode**, combinational, producing desired pair {hi_d, lo_d}:
  - HI_Z (00): {0,0}.
  - R_CURR (01): {~`pwm`, `pwm`}.
  - F_CURR (10): {`pwm`, ~`pwm`}.
  - R_BRK (11): {0, `pwm`}.
- **Per-phase dead-time unit.** There are three independent instances. State per instance: `des_q` (2 bits) and `dcnt` (8 bits). On each edge:
  - If {hi_d, lo_d} != `des_q`: `des_q` <= new pair, `dcnt` <= 0, outputs <= {0,0}.
  - Else if `dcnt` != DEAD_CYC: `dcnt`++, outputs <= {0,0}.
  - Else: outputs <= `des_q`.
- **Invariant:** the high and low outputs of any phase are never both 1. If `des_q`==11 ever occurs (unreachable by decode), outputs are forced {0,0}.
- **Select changes** (commutation step, brake entry) are treated like PWM edges and incur a full dead time.

## Timing
- **Reset** (async, immediate): `cnt`=0, `duty_q`=0, `pwm`=0, `pwm_synch`=0, all `des_q`=00, all `dcnt`=0, all six gate outputs 0.
- **After reset release:** gates stay 0 for at least DEAD_CYC+1 cycles. The first `pwm_synch` pulse appears at the edge after `cnt`==0 is observed.
- **Latency, `duty` to `pwm`:** a new `duty` is captured at the next `cnt`==2047 edge. `pwm` reflects it from the following edge onward.
- **Latency, `pwm`/sel to gates:**
  - A change of desired pair registered at edge E0 drives outputs to 0 at E0.
  - The new nonzero level appears at edge E0+DEAD_CYC+1.
  - A change to {0,0} is effective at E0.
- **Simultaneous events:** if the desired pair changes again during dead time, the unit restarts (`dcnt` <= 0). Outputs stay 0 until the pair is stable for DEAD_CYC+1 edges.
- **Short pulses:** if a `pwm` high or low phase is ≤ DEAD_CYC+1 cycles, the corresponding gate never asserts in that period.
- **Reset asserted mid-period:** all gates drop to 0 asynchronously. On release, operation restarts from `cnt`=0 with `duty_q`=0.
- **Gate on-time per period, steady state, F_CURR/R_CURR, `duty_q`=D, 0<D<2047:**
  - active-with-`pwm` gate: D−(DEAD_CYC+1) cycles (0 if negative);
  - complementary gate: 2048−D−(DEAD_CYC+1) cycles (0 if negative).

## Test plan
- **Reset:** hold `rst_n`=0 with sel=10 and duty=0x400. Required: all gates 0. After release, gates stay 0 for ≥33 cycles and `pwm_synch` pulses every 2048 cycles.
- **F_CURR:** DEAD_CYC=32, duty=0x400, selGrn=10, others 00. Required per period: highGrn high 991 cycles, lowGrn high 991 cycles, never both high; yellow and blue gates stay 0.
- **Brake:** duty=0x600, all sel=11. Required per period: all high gates 0; each low gate high 1536−33=1503 cycles.
- **Mid-period duty change:** change duty 0x100→0x700 at `cnt`=500. Required: current period keeps 256-cycle `pwm`; next period `pwm` is 1792 cycles.
- **Commutation step:** selGrn 10→01 while `pwm`=1. Required: highGrn falls at the registering edge, lowGrn rises exactly 33 edges later. Toggling sel back within 10 cycles restarts the dead-time count.
- **Extremes:** duty=0 with sel=10 gives highGrn=0 and lowGrn constantly 1 after dead time. duty=2047 gives lowGrn=0 because the 1-cycle low phase is shorter than the dead time.
